legv8_multicycle_ctrl: RTL and testbench
========================================

Name: legv8_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the LEGv8 datapath.
- Sequences fetch, decode, execute, memory and writeback for LDUR, STUR, ADD, SUB, AND, ORR, CBZ and B.
- Drives the immediate-select that steers the sign extender between the D, CB and B immediate fields.
- Handshakes with a variable-latency unified memory, counts retired instructions, and traps on illegal opcodes.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)
MEM_TIMEOUT, 255, max wait cycles on mem_ready before trap; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instruction  in  32  instruction register contents, valid from DECODE onward
zero  in  1  ALU zero flag, sampled in BR_CBZ
mem_ready  in  1  memory completes current request this cycle
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC update
pc_src  out  1  0 = PC+4, 1 = PC + (sext_imm << 2)
imm_sel  out  2  00 D-type [20:12] (9b), 01 CB-type [23:5] (19b), 10 B-type [25:0] (26b)
reg2loc  out  1  1 = read Rt (instr[4:0]) on read port 2
alu_src  out  1  1 = ALU B from sign-extended immediate
alu_op  out  2  00 add, 01 pass-B (CBZ test), 10 R-type funct decode
mem_req  out  1  memory request, held until mem_ready
mem_read  out  1  qualifies mem_req as read
mem_write  out  1  qualifies mem_req as write
iord  out  1  1 = memory address from ALU result, 0 = PC
reg_write  out  1  register file write enable
mem_to_reg  out  1  1 = writeback data from memory
retired  out  CNT_W  retired-instruction count
trap  out  1  sticky illegal-opcode / timeout flag
trap_cause  out  1  0 = illegal opcode, 1 = memory timeout

Behaviour:
- Async reset: state IDLE; all outputs 0; retired=0; trap=0; trap_cause=0; imm_sel=00; wait counter cleared. Reset mid-transaction drops mem_req in the same cycle.
- IDLE -> FETCH unconditionally on the next clock.
- FETCH: mem_req=1, mem_read=1, iord=0.
  - Stays while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
- DECODE: registers imm_sel from instruction. Decode rules:
  - [31:21]=7C2 -> LDUR
  - [31:21]=7C0 -> STUR
  - 458/658/450/550 -> R-type
  - [31:24]=B4 -> CBZ
  - [31:26]=000101 -> B
  - anything else -> TRAP with trap_cause=0
  - imm_sel: D for LDUR/STUR, CB for CBZ, B for B, held at last value for R-type.
  - reg2loc=1 for STUR and CBZ.
- MEM_ADDR: alu_src=1, alu_op=00, then MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: mem_req=1, mem_read=1, iord=1, wait for mem_ready, then WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, retire, go to FETCH.
- MEM_WR: mem_req=1, mem_write=1, iord=1, reg2loc=1. On mem_ready: retire, go to FETCH.
- EXEC_R: alu_src=0, alu_op=10, then WB_R.
- WB_R: reg_write=1, mem_to_reg=0, retire, go to FETCH.
- BR_CBZ: alu_op=01, reg2loc=1. pc_write=zero, pc_src=1. Retire, go to FETCH.
- BR_B: pc_write=1, pc_src=1, retire, go to FETCH.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - R-type: 4 cycles FETCH->FETCH
  - LDUR: 5 cycles
  - STUR: 4 cycles
  - CBZ/B: 3 cycles
  - Each memory wait cycle adds 1.
- Memory handshake:
  - mem_req, mem_read/mem_write and iord stay stable until the cycle mem_ready=1 is sampled.
  - mem_ready while mem_req=0 is ignored.
  - mem_read and mem_write are never both 1.
- Timeout: the wait counter increments on each mem_req cycle with mem_ready=0. Reaching MEM_TIMEOUT enters TRAP with trap_cause=1.
- Retire: retired increments by 1 on each retire cycle; wraps from all-ones to 0.
- TRAP: all strobes 0, trap=1, stays until reset.
- pc_write and reg_write are never asserted in the same cycle.

Test Plan:
- Reset, then ADD 0x8B020020 with mem_ready tied 1 -> ir_write in cycle 2, reg_write in WB_R cycle 5; retired=1; imm_sel holds 00.
- LDUR 0xF84083E1, memory holds 3 wait cycles on the data read -> imm_sel=00, mem_req+iord held 4 cycles, then WB_MEM with reg_write=1 and mem_to_reg=1; 8 cycles total.
- CBZ 0xB4000062 with zero=1 then zero=0 -> imm_sel=01; pc_write=1, pc_src=1 only for zero=1; retired increments both times.
- B 0x14000004 -> imm_sel=10, pc_write=1, pc_src=1 in cycle 3; STUR 0xF80083E1 -> mem_write=1, reg2loc=1, reg_write never 1.
- Illegal 0xFFFFFFFF -> TRAP, trap=1, trap_cause=0, all strobes 0 for 20 cycles; MEM_TIMEOUT=4 with mem_ready stuck 0 -> trap_cause=1 after 4 wait cycles.
- rst_n pulsed low mid-MEM_RD -> mem_req drops asynchronously; retired=0; restart IDLE->FETCH. CNT_W=4, 17 retirements -> retired=1.

Source files
------------

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/execute/memory/writeback sequencing,
// variable-latency memory handshake with timeout, retired-instruction count and trap.
//   state    | meaning
//   IDLE     | post-reset, one idle cycle
//   FETCH    | instruction read, PC+4 on completion
//   DECODE   | classify opcode, latch immediate select
//   MEM_ADDR | ALU computes base + D-offset
//   MEM_RD   | data read in flight
//   WB_MEM   | load data to register file
//   MEM_WR   | data write in flight
//   EXEC_R   | R-type ALU operation
//   WB_R     | ALU result to register file
//   BR_CBZ   | conditional branch on zero
//   BR_B     | unconditional branch
//   TRAP     | illegal opcode or memory timeout, held until reset
`timescale 1ns/1ps

module legv8_multicycle_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       imm_sel,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic             trap_cause
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  localparam logic [1:0] IMM_D  = 2'b00;
  localparam logic [1:0] IMM_CB = 2'b01;
  localparam logic [1:0] IMM_B  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    EXEC_R,
    WB_R,
    BR_CBZ,
    BR_B,
    TRAP
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        imm_sel_nxt;
  logic              retire;
  logic              trap_enter;
  logic              cause_nxt;
  logic              timeout_hit;

  logic [10:0] opcode;
  logic        is_ldur, is_stur, is_rtype, is_cbz, is_b;

  // Low instruction fields feed only the datapath (register numbers, immediates).
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[20:0];

  assign opcode   = instruction[31:21];
  assign is_ldur  = (opcode == 11'h7C2);
  assign is_stur  = (opcode == 11'h7C0);
  assign is_rtype = (opcode == 11'h458) || (opcode == 11'h658) ||
                    (opcode == 11'h450) || (opcode == 11'h550);
  assign is_cbz   = (instruction[31:24] == 8'hB4);
  assign is_b     = (instruction[31:26] == 6'b000101);

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
  assign trap        = (state == TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imm_sel    <= IMM_D;
      retired    <= '0;
      trap_cause <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state   <= state_nxt;
      imm_sel <= imm_sel_nxt;
      if (retire)
        retired <= retired + CNT_W'(1);
      if (trap_enter)
        trap_cause <= cause_nxt;
      if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt   = state;
    imm_sel_nxt = imm_sel;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg2loc     = 1'b0;
    alu_src     = 1'b0;
    alu_op      = ALU_ADD;
    mem_req     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    retire      = 1'b0;
    trap_enter  = 1'b0;
    cause_nxt   = 1'b0;

    case (state)
      IDLE: state_nxt = FETCH;

      FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = DECODE;
        end else if (timeout_hit) begin
          state_nxt  = TRAP;
          trap_enter = 1'b1;
          cause_nxt  = 1'b1;
        end
      end

      DECODE: begin
        reg2loc = is_stur || is_cbz;
        if (is_ldur || is_stur) begin
          imm_sel_nxt = IMM_D;
          state_nxt   = MEM_ADDR;
        end else if (is_rtype) begin
          state_nxt = EXEC_R;
        end else if (is_cbz) begin
          imm_sel_nxt = IMM_CB;
          state_nxt   = BR_CBZ;
        end else if (is_b) begin
          imm_sel_nxt = IMM_B;
          state_nxt   = BR_B;
        end else begin
          state_nxt  = TRAP;
          trap_enter = 1'b1;
        end
      end

      MEM_ADDR: begin
        alu_src   = 1'b1;
        alu_op    = ALU_ADD;
        state_nxt = is_stur ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_nxt = WB_MEM;
        end else if (timeout_hit) begin
          state_nxt  = TRAP;
          trap_enter = 1'b1;
          cause_nxt  = 1'b1;
        end
      end

      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nxt  = FETCH;
      end

      MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        reg2loc   = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end else if (timeout_hit) begin
          state_nxt  = TRAP;
          trap_enter = 1'b1;
          cause_nxt  = 1'b1;
        end
      end

      EXEC_R: begin
        alu_op    = ALU_RTYPE;
        state_nxt = WB_R;
      end

      WB_R: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end

      BR_CBZ: begin
        alu_op    = ALU_PASSB;
        reg2loc   = 1'b1;
        pc_write  = zero;
        pc_src    = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end

      BR_B: begin
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end

      TRAP: state_nxt = TRAP;

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: table of instructions with per-instruction
// expected strobe counts via a scoreboard queue, plus reset/trap/timeout sequences.
`timescale 1ns/1ps

module tb_legv8_multicycle_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      instruction = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             ir_write, pc_write, pc_src, reg2loc, alu_src;
  logic [1:0]       imm_sel, alu_op;
  logic             mem_req, mem_read, mem_write, iord, reg_write, mem_to_reg;
  logic [CNT_W-1:0] retired;
  logic             trap, trap_cause;

  legv8_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .imm_sel(imm_sel), .reg2loc(reg2loc), .alu_src(alu_src),
    .alu_op(alu_op), .mem_req(mem_req), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .retired(retired), .trap(trap),
    .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        z;
    int          dwait;
    int          cyc, regw, m2r, br, memw, rd, r2l, asrc, aop;
    logic [1:0]  imm;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int data_wait = 0;
  int waited    = 0;
  bit stuck_low = 1'b0;
  int exp_ret   = 0;
  int acc_regw, acc_m2r, acc_br, acc_memw, acc_rd, acc_r2l, acc_asrc, acc_aop;
  int acc_irw, acc_pcw;

  function automatic vec_t mk(string n, logic [31:0] ins, logic z, int dw, int cyc,
                              int regw, int m2r, int br, int memw, int rd, int r2l,
                              int asrc, int aop, logic [1:0] imm);
    vec_t v;
    v.name = n; v.instr = ins; v.z = z; v.dwait = dw; v.cyc = cyc;
    v.regw = regw; v.m2r = m2r; v.br = br; v.memw = memw; v.rd = rd;
    v.r2l = r2l; v.asrc = asrc; v.aop = aop; v.imm = imm;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: data accesses stall for data_wait cycles; fetches complete at once.
  task automatic tick();
    @(negedge clk);
    #1;
    if (stuck_low)
      mem_ready = 1'b0;
    else if (mem_req && iord && waited < data_wait) begin
      mem_ready = 1'b0;
      waited++;
    end else
      mem_ready = 1'b1;
    #1;
  endtask

  task automatic accum();
    if (reg_write)              acc_regw++;
    if (reg_write && mem_to_reg) acc_m2r++;
    if (pc_write && pc_src)     acc_br++;
    if (mem_req && mem_write)   acc_memw++;
    if (mem_req && mem_read && iord) acc_rd++;
    if (reg2loc)                acc_r2l++;
    if (alu_src)                acc_asrc++;
    if (alu_op != 2'b00)        acc_aop++;
    if (ir_write)               acc_irw++;
    if (pc_write)               acc_pcw++;
    check("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
    check("pcw_regw_exclusive", {31'd0, pc_write & reg_write}, 32'd0);
  endtask

  // Entered with the DUT sampled in FETCH; returns sampled in the next FETCH.
  task automatic run_instr(input vec_t v);
    vec_t e;
    int   cyc;
    bit   done;
    instruction = v.instr;
    zero        = v.z;
    data_wait   = v.dwait;
    waited      = 0;
    sb.push_back(v);
    acc_regw = 0; acc_m2r = 0; acc_br = 0; acc_memw = 0; acc_rd = 0;
    acc_r2l = 0; acc_asrc = 0; acc_aop = 0; acc_irw = 0; acc_pcw = 0;
    accum();
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 40) begin
      tick();
      if (mem_req && !iord) done = 1'b1;
      else begin
        accum();
        cyc++;
      end
    end
    e = sb.pop_front();
    check({e.name, " completes"}, {31'd0, done}, 32'd1);
    check({e.name, " cycles"}, cyc, e.cyc);
    check({e.name, " reg_write"}, acc_regw, e.regw);
    check({e.name, " mem_to_reg"}, acc_m2r, e.m2r);
    check({e.name, " branch"}, acc_br, e.br);
    check({e.name, " pc_write"}, acc_pcw, 1 + e.br);
    check({e.name, " ir_write"}, acc_irw, 1);
    check({e.name, " mem_write"}, acc_memw, e.memw);
    check({e.name, " data_read"}, acc_rd, e.rd);
    check({e.name, " reg2loc"}, acc_r2l, e.r2l);
    check({e.name, " alu_src"}, acc_asrc, e.asrc);
    check({e.name, " alu_op"}, acc_aop, e.aop);
    check({e.name, " imm_sel"}, {30'd0, imm_sel}, {30'd0, e.imm});
    exp_ret = (exp_ret + 1) % (1 << CNT_W);
    check({e.name, " retired"}, {28'd0, retired}, exp_ret);
  endtask

  function automatic logic [31:0] strobes();
    return {19'd0, ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op,
            mem_req, mem_read, mem_write, iord, reg_write, mem_to_reg};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    //            name        instr         z  dw cyc rw m2r br mw rd r2l as aop imm
    vecs[0]  = mk("ADD",   32'h8B020020, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00);
    vecs[1]  = mk("LDUR3", 32'hF84083E1, 0, 3, 8, 1, 1, 0, 0, 4, 0, 1, 0, 2'b00);
    vecs[2]  = mk("CBZ_Z1",32'hB4000062, 1, 0, 3, 0, 0, 1, 0, 0, 2, 0, 1, 2'b01);
    vecs[3]  = mk("CBZ_Z0",32'hB4000062, 0, 0, 3, 0, 0, 0, 0, 0, 2, 0, 1, 2'b01);
    vecs[4]  = mk("ADD_H", 32'h8B020020, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 2'b01);
    vecs[5]  = mk("B",     32'h14000004, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10);
    vecs[6]  = mk("SUB",   32'hCB020020, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 2'b10);
    vecs[7]  = mk("STUR",  32'hF80083E1, 0, 0, 4, 0, 0, 0, 1, 0, 2, 1, 0, 2'b00);
    vecs[8]  = mk("AND",   32'h8A020020, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00);
    vecs[9]  = mk("STUR2", 32'hF80083E1, 0, 2, 6, 0, 0, 0, 3, 0, 4, 1, 0, 2'b00);
    vecs[10] = mk("ORR",   32'hAA020020, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00);
    vecs[11] = mk("LDUR0", 32'hF84083E1, 0, 0, 5, 1, 1, 0, 0, 1, 0, 1, 0, 2'b00);
    vecs[12] = mk("CBZ_Z1b",32'hB4000062,1, 0, 3, 0, 0, 1, 0, 0, 2, 0, 1, 2'b01);

    // Reset state
    rst_n = 1'b0;
    #12;
    check("reset outputs", {11'd0, strobes()[12:0], imm_sel, retired, trap, trap_cause}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #2;
    check("idle strobes", strobes(), 32'd0);
    check("idle trap", {31'd0, trap}, 32'd0);
    tick();
    check("fetch ir_write", {31'd0, ir_write}, 32'd1);
    check("fetch pc_write", {31'd0, pc_write}, 32'd1);
    check("fetch pc_src", {31'd0, pc_src}, 32'd0);
    check("fetch mem_read", {31'd0, mem_read}, 32'd1);
    check("fetch iord", {31'd0, iord}, 32'd0);

    for (int i = 0; i < 13; i++) run_instr(vecs[i]);
    for (int i = 0; i < 4; i++) run_instr(vecs[5]);
    check("retired wrap after 17", {28'd0, retired}, 32'd1);

    // Reset while a data read is stalled
    instruction = 32'hF84083E1;
    data_wait = 10;
    waited = 0;
    found = 0;
    for (int k = 0; k < 6 && found == 0; k++) begin
      tick();
      if (mem_req && iord) found = 1;
    end
    check("reached MEM_RD", found, 1);
    tick();
    check("MEM_RD held mem_req", {31'd0, mem_req & mem_read & iord}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async drop mem_req", {31'd0, mem_req}, 32'd0);
    check("async drop iord", {31'd0, iord}, 32'd0);
    check("async retired clear", {28'd0, retired}, 32'd0);
    data_wait = 0;
    exp_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("restart idle", strobes(), 32'd0);
    tick();
    check("restart fetch", {31'd0, mem_req & ~iord & ir_write}, 32'd1);
    run_instr(vecs[0]);

    // Illegal opcode
    instruction = 32'hFFFFFFFF;
    tick();
    check("decode no trap yet", {31'd0, trap}, 32'd0);
    tick();
    for (int k = 0; k < 20; k++) begin
      check("illegal trap", {31'd0, trap}, 32'd1);
      check("illegal cause", {31'd0, trap_cause}, 32'd0);
      check("illegal strobes", strobes(), 32'd0);
      tick();
    end
    check("illegal retired held", {28'd0, retired}, 32'd1);

    // Fetch timeout with memory never ready
    @(negedge clk);
    rst_n = 1'b0;
    stuck_low = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("trap cleared by reset", {31'd0, trap}, 32'd0);
    rst_n = 1'b1;
    #2;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("wait mem_req", {31'd0, mem_req & mem_read & ~mem_write & ~iord}, 32'd1);
      check("wait ir_write", {31'd0, ir_write}, 32'd0);
      check("wait no trap", {31'd0, trap}, 32'd0);
      tick();
    end
    check("timeout trap", {31'd0, trap}, 32'd1);
    check("timeout cause", {31'd0, trap_cause}, 32'd1);
    check("timeout strobes", strobes(), 32'd0);
    stuck_low = 1'b0;
    tick();
    check("timeout trap sticky", {31'd0, trap & trap_cause}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
